denoise_median3x3: RTL and testbench

// - Streaming 3x3 per-channel median denoiser for a fixed-size RGB frame, used as a pipeline stage of the ISP.
// - Accepts one colour component per cycle (R, G, B in that order) and buffers two prior rows.
// - Emits the "valid" (non-padded) output region as a serial R, G, B component stream.
// - A 12x6 frame (72 pixels) yields a 10x4 output (40 pixels).

---
 rtl/denoise_median3x3_pkg.sv | 22 ++
 rtl/denoise_median3x3_median9.sv | 37 +++
 rtl/denoise_median3x3.sv | 203 ++++++++++++++++++++
 tb/tb_denoise_median3x3.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/denoise_median3x3_pkg.sv
// Shared definitions for the 3x3 median denoiser.
//   ColorDepth : default bits per colour component
//   color_e    : channel codes carried on color_in / color_out
//   seq_e      : output sequencer states (R is emitted directly, G and B follow)
package denoise_median3x3_pkg;

    localparam int unsigned ColorDepth = 8;

    typedef enum logic [2:0] {
        ColRed   = 3'd0,
        ColGreen = 3'd1,
        ColBlue  = 3'd2,
        ColVoid  = 3'd3
    } color_e;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqGreen,
        SeqBlue
    } seq_e;

endpackage

// File: rtl/denoise_median3x3_median9.sv
// Combinational median of nine unsigned values using a 19-element compare-swap network.
//   vals_i : nine input values, any order
//   med_o  : 5th smallest of the nine
module denoise_median3x3_median9
    import denoise_median3x3_pkg::*;
#(
    parameter int unsigned W = ColorDepth
) (
    input  logic [8:0][W-1:0] vals_i,
    output logic [W-1:0]      med_o
);

    // Each step leaves min in slot PairLo[k] and max in slot PairHi[k]. The network only
    // guarantees slot 4; the other slots are not fully sorted.
    localparam int PairLo [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
    localparam int PairHi [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

    logic [8:0][W-1:0] p;
    logic [W-1:0]      lo_v;
    logic [W-1:0]      hi_v;

    always_comb begin
        p    = vals_i;
        lo_v = '0;
        hi_v = '0;
        for (int k = 0; k < 19; k++) begin
            lo_v = p[PairLo[k]];
            hi_v = p[PairHi[k]];
            if (lo_v > hi_v) begin
                p[PairLo[k]] = hi_v;
                p[PairHi[k]] = lo_v;
            end
        end
        med_o = p[4];
    end

endmodule

// File: rtl/denoise_median3x3.sv
// Streaming 3x3 per-channel median denoiser for a fixed-size RGB frame.
// Components arrive serially (R, G, B); B completes a pixel. Once a full 3x3 window exists
// the three channel medians are computed in parallel and emitted serially as R, G, B.
//   clk          : clock, rising edge
//   rst_n        : synchronous reset, active HIGH despite the name
//   pixel_in     : component value          valid_in   : component qualifier
//   color_in     : 0=R 1=G 2=B, else VOID   last_col_in: final pixel of the frame
//   pixel_out    : median of channel color_out
//   valid_out    : output qualifier         color_out  : channel code, 3 when idle
//   last_col_out : high on the three components of the final output pixel
module denoise_median3x3
    import denoise_median3x3_pkg::*;
#(
    parameter int unsigned COLOR_DEPTH = ColorDepth,
    parameter int unsigned IMG_W       = 12,
    parameter int unsigned IMG_H       = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COLOR_DEPTH-1:0] pixel_in,
    input  logic                   valid_in,
    input  logic [2:0]             color_in,
    input  logic                   last_col_in,
    output logic [COLOR_DEPTH-1:0] pixel_out,
    output logic                   valid_out,
    output logic [2:0]             color_out,
    output logic                   last_col_out
);

    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);

    typedef logic [2:0][COLOR_DEPTH-1:0] pix_t;  // [0]=R [1]=G [2]=B

    logic [COLOR_DEPTH-1:0] r_q, g_q;
    logic [ColW-1:0]        col_q, col_d;
    logic [RowW-1:0]        row_q, row_d;

    pix_t lb1_q [IMG_W];  // row r-1
    pix_t lb2_q [IMG_W];  // row r-2
    pix_t win_q [3][2];   // [row r-2..r][column c-2, c-1]
    pix_t nc    [3];      // incoming column c, rows r-2..r
    pix_t pix_new;

    logic complete, at_last_pos, frame_end, win_ok;

    assign complete    = valid_in && (color_in == ColBlue);
    assign at_last_pos = (row_q == RowW'(IMG_H - 1)) && (col_q == ColW'(IMG_W - 1));
    assign frame_end   = last_col_in || at_last_pos;
    assign win_ok      = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
    assign pix_new     = {pixel_in, g_q, r_q};

    // ---------------- position counters and component assembly ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (complete) begin
            if (frame_end) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == ColW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_q   <= '0;
            g_q   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            if (valid_in && (color_in == ColRed))   r_q <= pixel_in;
            if (valid_in && (color_in == ColGreen)) g_q <= pixel_in;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------- line buffers and window (contents need no reset) ----------------
    always_comb begin
        nc[0] = lb2_q[col_q];
        nc[1] = lb1_q[col_q];
        nc[2] = pix_new;
    end

    always_ff @(posedge clk) begin
        if (complete) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= pix_new;
            for (int rr = 0; rr < 3; rr++) begin
                win_q[rr][0] <= win_q[rr][1];
                win_q[rr][1] <= nc[rr];
            end
        end
    end

    // ---------------- medians over the window including the incoming column ----------------
    logic [8:0][COLOR_DEPTH-1:0] vals [3];
    logic [COLOR_DEPTH-1:0]      med  [3];

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            for (int rr = 0; rr < 3; rr++) begin
                vals[ch][rr*3 + 0] = win_q[rr][0][ch];
                vals[ch][rr*3 + 1] = win_q[rr][1][ch];
                vals[ch][rr*3 + 2] = nc[rr][ch];
            end
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_med
        denoise_median3x3_median9 #(
            .W (COLOR_DEPTH)
        ) u_median9 (
            .vals_i (vals[ch]),
            .med_o  (med[ch])
        );
    end

    // ---------------- output sequencer ----------------
    seq_e                   seq_q, seq_d;
    logic [COLOR_DEPTH-1:0] med_g_q, med_g_d, med_b_q, med_b_d;
    logic                   last_pend_q, last_pend_d;
    logic [COLOR_DEPTH-1:0] pix_out_q, pix_out_d;
    logic                   valid_out_q, valid_out_d;
    logic [2:0]             color_out_q, color_out_d;
    logic                   last_out_q, last_out_d;

    always_comb begin
        seq_d       = seq_q;
        med_g_d     = med_g_q;
        med_b_d     = med_b_q;
        last_pend_d = last_pend_q;
        pix_out_d   = '0;
        valid_out_d = 1'b0;
        color_out_d = ColVoid;
        last_out_d  = 1'b0;
        if (complete && win_ok) begin
            // Red goes out straight from the network; G and B are held for the next two cycles.
            pix_out_d   = med[0];
            valid_out_d = 1'b1;
            color_out_d = ColRed;
            last_out_d  = at_last_pos;
            last_pend_d = at_last_pos;
            med_g_d     = med[1];
            med_b_d     = med[2];
            seq_d       = SeqGreen;
        end else begin
            unique case (seq_q)
                SeqGreen: begin
                    pix_out_d   = med_g_q;
                    valid_out_d = 1'b1;
                    color_out_d = ColGreen;
                    last_out_d  = last_pend_q;
                    seq_d       = SeqBlue;
                end
                SeqBlue: begin
                    pix_out_d   = med_b_q;
                    valid_out_d = 1'b1;
                    color_out_d = ColBlue;
                    last_out_d  = last_pend_q;
                    seq_d       = SeqIdle;
                end
                default: begin
                    seq_d = SeqIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            seq_q       <= SeqIdle;
            med_g_q     <= '0;
            med_b_q     <= '0;
            last_pend_q <= 1'b0;
            pix_out_q   <= '0;
            valid_out_q <= 1'b0;
            color_out_q <= ColVoid;
            last_out_q  <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            med_g_q     <= med_g_d;
            med_b_q     <= med_b_d;
            last_pend_q <= last_pend_d;
            pix_out_q   <= pix_out_d;
            valid_out_q <= valid_out_d;
            color_out_q <= color_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign pixel_out    = pix_out_q;
    assign valid_out    = valid_out_q;
    assign color_out    = color_out_q;
    assign last_col_out = last_out_q;

endmodule

// File: tb/tb_denoise_median3x3.sv
// Directed bench for denoise_median3x3 with a scoreboard queue of expected output components.
module tb_denoise_median3x3;

    localparam int W = 8;
    localparam int IW = 12;
    localparam int IH = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pixel_in;
    logic         valid_in;
    logic [2:0]   color_in;
    logic         last_col_in;
    logic [W-1:0] pixel_out;
    logic         valid_out;
    logic [2:0]   color_out;
    logic         last_col_out;

    denoise_median3x3 #(
        .COLOR_DEPTH (W),
        .IMG_W       (IW),
        .IMG_H       (IH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .valid_in     (valid_in),
        .color_in     (color_in),
        .last_col_in  (last_col_in),
        .pixel_out    (pixel_out),
        .valid_out    (valid_out),
        .color_out    (color_out),
        .last_col_out (last_col_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   col;
        logic [W-1:0] val;
        logic         last;
        longint       due;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     out_pix = 0;
    longint cyc = 0;
    int     fr [3][IH][IW];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference median: full sort of the 3x3 neighbourhood centred at (r, c).
    function automatic int med9(int ch, int r, int c);
        int v[9];
        int k = 0;
        int t;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                v[k] = fr[ch][r+dr][c+dc];
                k++;
            end
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        return v[4];
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (valid_out) begin
            if (color_out == 3'd2) out_pix++;
            checks++;
            if (q.size() == 0) begin
                assert (valid_out === 1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_out cyc=%0d observed col=%0d val=%0d last=%0b expected none",
                           cyc, color_out, pixel_out, last_col_out);
                end
            end else begin
                e = q.pop_front();
                assert ({color_out, pixel_out, last_col_out} === {e.col, e.val, e.last}) else begin
                    errors++;
                    $error("FAIL out_value cyc=%0d observed col=%0d val=%0d last=%0b expected col=%0d val=%0d last=%0b",
                           cyc, color_out, pixel_out, last_col_out, e.col, e.val, e.last);
                end
                checks++;
                assert (cyc === e.due) else begin
                    errors++;
                    $error("FAIL out_timing observed cyc=%0d expected cyc=%0d", cyc, e.due);
                end
            end
        end else if (q.size() > 0) begin
            checks++;
            assert (q[0].due > cyc) else begin
                errors++;
                $error("FAIL missed_out cyc=%0d observed valid_out=0 expected col=%0d val=%0d",
                       cyc, q[0].col, q[0].val);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one pixel (R, G, B) then `gap` idle cycles after each component; pushes `nexp`
    // expected output components when the pixel closes a valid window.
    task automatic send_pixel(int r, int c, int gap, int nexp);
        bit lst = (r == IH-1) && (c == IW-1);
        for (int ch = 0; ch < 3; ch++) begin
            pixel_in    = W'(fr[ch][r][c]);
            color_in    = 3'(ch);
            valid_in    = 1'b1;
            last_col_in = lst;
            if (ch == 2 && r >= 2 && c >= 2) begin
                for (int k = 0; k < nexp; k++) begin
                    exp_t e;
                    e.col  = 3'(k);
                    e.val  = W'(med9(k, r-1, c-1));
                    e.last = lst;
                    e.due  = cyc + 1 + k;
                    q.push_back(e);
                end
            end
            tick();
            valid_in    = 1'b0;
            last_col_in = 1'b0;
            color_in    = 3'd3;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic send_frame(int gap);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                send_pixel(r, c, gap, 3);
    endtask

    task automatic fill_flat(int v);
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < IH; r++)
                for (int c = 0; c < IW; c++)
                    fr[ch][r][c] = v;
    endtask

    task automatic check_frame(string tag, int base);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        assert (out_pix - base === 40) else begin
            errors++;
            $error("FAIL %s_count observed %0d expected 40", tag, out_pix - base);
        end
        checks++;
        assert (q.size() === 0) else begin
            errors++;
            $error("FAIL %s_pending observed %0d expected 0", tag, q.size());
        end
    endtask

    task automatic check_reset(string tag);
        checks++;
        assert ({valid_out, pixel_out, color_out, last_col_out} === {1'b0, 8'd0, 3'd3, 1'b0}) else begin
            errors++;
            $error("FAIL %s observed v=%0b px=%0d col=%0d last=%0b expected v=0 px=0 col=3 last=0",
                   tag, valid_out, pixel_out, color_out, last_col_out);
        end
    endtask

    initial begin
        int base;
        rst_n       = 1'b1;
        pixel_in    = '0;
        valid_in    = 1'b0;
        color_in    = 3'd3;
        last_col_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_reset("reset_outputs");
        rst_n = 1'b0;
        tick();

        // Flat 100 frame, back-to-back components.
        fill_flat(100);
        base = out_pix;
        send_frame(0);
        check_frame("flat100", base);

        // VOID with valid_in=1 must be ignored: no output and no position advance.
        valid_in = 1'b1;
        color_in = 3'd3;
        pixel_in = 8'hAA;
        for (int i = 0; i < 50; i++) tick();
        valid_in = 1'b0;
        checks++;
        assert (out_pix - base === 40) else begin
            errors++;
            $error("FAIL void_hold observed %0d expected 40", out_pix - base);
        end

        // Impulse at (2,2) in every channel is fully suppressed.
        fill_flat(0);
        for (int ch = 0; ch < 3; ch++) fr[ch][2][2] = 255;
        base = out_pix;
        send_frame(0);
        check_frame("impulse", base);

        // Channel ramps with two idle cycles between components.
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                fr[0][r][c] = c * 10;
                fr[1][r][c] = r * 20;
                fr[2][r][c] = 255 - c;
            end
        base = out_pix;
        send_frame(2);
        check_frame("ramp_gap2", base);

        // Abort at pixel 30: its R is already registered, G/B must be killed by reset.
        fill_flat(77);
        for (int p = 0; p < 29; p++) send_pixel(p / IW, p % IW, 0, 3);
        send_pixel(29 / IW, 29 % IW, 0, 1);
        rst_n = 1'b1;
        tick();
        tick();
        check_reset("midframe_reset");
        rst_n = 1'b0;
        tick();
        checks++;
        assert (q.size() === 0) else begin
            errors++;
            $error("FAIL abort_pending observed %0d expected 0", q.size());
        end

        fill_flat(50);
        base = out_pix;
        send_frame(0);
        check_frame("flat50_after_reset", base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
